mostrador_sequencia: RTL and testbench

- Game-to-player direction of the memory game: plays the stored colour sequence on the LEDs before the player's turn.
- On a start pulse, reads sequence entries 0..nivel from an external synchronous 16x4 ROM and lights each entry for a fixed time, with a dark gap after each.
- Signals completion so the game controller can hand over to the button-capture datapath.

---
 rtl/mostrador_sequencia_pkg.sv | 23 ++
 rtl/mostrador_sequencia_contador_tempo.sv | 43 ++++
 rtl/mostrador_sequencia.sv | 153 +++++++++++++++
 tb/tb_mostrador_sequencia.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mostrador_sequencia_pkg.sv
// ============================================================================
// mostrador_sequencia_pkg: shared state encoding and widths for the sequence player.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mostrador_sequencia_pkg;

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        ENDERECA  = 3'd1,
        CAPTURA   = 3'd2,
        LIGADO    = 3'd3,
        DESLIGADO = 3'd4,
        FIM       = 3'd5
    } estado_t;

    localparam int LARGURA_LED      = 4;
    localparam int LARGURA_ENDERECO = 4;

endpackage

`default_nettype wire

// File: rtl/mostrador_sequencia_contador_tempo.sv
// ============================================================================
// contador_tempo: saturating cycle timer with sync clear and a terminal flag at limite-1.
// Revision: 1.0
// ============================================================================
`default_nettype none

module contador_tempo #(
    parameter int LARGURA = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               limpar,
    input  logic               habilitar,
    input  logic [LARGURA-1:0] limite,
    output logic               terminal
);

    logic [LARGURA-1:0] contagem_q;
    logic [LARGURA-1:0] contagem_d;

    always_comb begin
        contagem_d = contagem_q;
        if (limpar) begin
            contagem_d = '0;
        end else if (habilitar && (contagem_q != '1)) begin
            contagem_d = contagem_q + LARGURA'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem_q <= '0;
        end else begin
            contagem_q <= contagem_d;
        end
    end

    // Flag the last cycle of the phase so the controller can leave on this edge.
    assign terminal = (contagem_q == (limite - LARGURA'(1)));

endmodule

`default_nettype wire

// File: rtl/mostrador_sequencia.sv
// ============================================================================
// mostrador_sequencia: plays ROM entries 0..nivel on the LEDs, lit then dark each.
// Optional debug outputs db_estado/db_indice under MOSTRADOR_DEPURACAO_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mostrador_sequencia
    import mostrador_sequencia_pkg::*;
#(
    parameter int T_LIGADO    = 1000,
    parameter int T_DESLIGADO = 500
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        iniciar,
    input  logic                        abortar,
    input  logic [LARGURA_ENDERECO-1:0] nivel,
    output logic [LARGURA_ENDERECO-1:0] endereco,
    input  logic [LARGURA_LED-1:0]      dado_rom,
    output logic [LARGURA_LED-1:0]      leds,
`ifdef MOSTRADOR_DEPURACAO_EN
    output logic [2:0]                  db_estado,
    output logic [LARGURA_ENDERECO-1:0] db_indice,
`endif
    output logic                        ocupado,
    output logic                        pronto
);

    localparam int T_MAXIMO      = (T_LIGADO > T_DESLIGADO) ? T_LIGADO : T_DESLIGADO;
    localparam int LARGURA_TEMPO = $clog2(T_MAXIMO) + 1;

    estado_t                       estado_q,   estado_d;
    logic [LARGURA_ENDERECO-1:0]   indice_q,   indice_d;
    logic [LARGURA_ENDERECO-1:0]   nivel_q,    nivel_d;
    logic [LARGURA_ENDERECO-1:0]   endereco_q, endereco_d;
    logic [LARGURA_LED-1:0]        leds_q,     leds_d;
    logic                          ocupado_q,  ocupado_d;
    logic                          pronto_q,   pronto_d;

    logic                          tempo_limpar;
    logic                          tempo_habilitar;
    logic                          tempo_terminal;
    logic [LARGURA_TEMPO-1:0]      tempo_limite;

    assign tempo_limite = (estado_q == LIGADO) ? LARGURA_TEMPO'(T_LIGADO)
                                               : LARGURA_TEMPO'(T_DESLIGADO);

    contador_tempo #(
        .LARGURA (LARGURA_TEMPO)
    ) u_contador_tempo (
        .clock     (clock),
        .reset     (reset),
        .limpar    (tempo_limpar),
        .habilitar (tempo_habilitar),
        .limite    (tempo_limite),
        .terminal  (tempo_terminal)
    );

    always_comb begin
        estado_d        = estado_q;
        indice_d        = indice_q;
        nivel_d         = nivel_q;
        endereco_d      = endereco_q;
        leds_d          = '0;
        tempo_limpar    = 1'b1;
        tempo_habilitar = 1'b0;

        if (abortar) begin
            estado_d   = OCIOSO;
            indice_d   = '0;
            endereco_d = '0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (iniciar) begin
                        nivel_d    = nivel;
                        indice_d   = '0;
                        endereco_d = '0;
                        estado_d   = ENDERECA;
                    end
                end
                ENDERECA: estado_d = CAPTURA;
                CAPTURA: begin
                    leds_d   = dado_rom;
                    estado_d = LIGADO;
                end
                LIGADO: begin
                    if (tempo_terminal) begin
                        estado_d = DESLIGADO;
                    end else begin
                        leds_d          = leds_q;
                        tempo_limpar    = 1'b0;
                        tempo_habilitar = 1'b1;
                    end
                end
                DESLIGADO: begin
                    if (tempo_terminal) begin
                        if (indice_q == nivel_q) begin
                            estado_d = FIM;
                        end else begin
                            indice_d   = indice_q + LARGURA_ENDERECO'(1);
                            endereco_d = indice_q + LARGURA_ENDERECO'(1);
                            estado_d   = ENDERECA;
                        end
                    end else begin
                        tempo_limpar    = 1'b0;
                        tempo_habilitar = 1'b1;
                    end
                end
                FIM:     estado_d = OCIOSO;
                default: estado_d = OCIOSO;
            endcase
        end

        // Flags follow the next state so they line up with it as registered outputs.
        ocupado_d = (estado_d != OCIOSO);
        pronto_d  = (estado_d == FIM);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= OCIOSO;
            indice_q   <= '0;
            nivel_q    <= '0;
            endereco_q <= '0;
            leds_q     <= '0;
            ocupado_q  <= 1'b0;
            pronto_q   <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            indice_q   <= indice_d;
            nivel_q    <= nivel_d;
            endereco_q <= endereco_d;
            leds_q     <= leds_d;
            ocupado_q  <= ocupado_d;
            pronto_q   <= pronto_d;
        end
    end

    assign endereco = endereco_q;
    assign leds     = leds_q;
    assign ocupado  = ocupado_q;
    assign pronto   = pronto_q;

`ifdef MOSTRADOR_DEPURACAO_EN
    assign db_estado = estado_q;
    assign db_indice = indice_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mostrador_sequencia.sv
// ============================================================================
// tb_mostrador_sequencia: directed scoreboard bench for the sequence player.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mostrador_sequencia;

    localparam int TL = 3;
    localparam int TD = 2;
    localparam int N  = 2 + TL + TD;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       abortar;
    logic [3:0] nivel;
    logic [3:0] endereco;
    logic [3:0] dado_rom;
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;

    logic [3:0] rom [16];

    typedef struct packed {
        logic [3:0] leds;
        logic [3:0] endereco;
        logic       ocupado;
        logic       pronto;
    } obs_t;

    obs_t esperado_q [$];
    int   n_assert = 0;
    int   n_falha  = 0;

    always #5 clock = ~clock;

    always @(posedge clock) dado_rom <= rom[endereco];

    mostrador_sequencia #(
        .T_LIGADO    (TL),
        .T_DESLIGADO (TD)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .iniciar  (iniciar),
        .abortar  (abortar),
        .nivel    (nivel),
        .endereco (endereco),
        .dado_rom (dado_rom),
        .leds     (leds),
        .ocupado  (ocupado),
        .pronto   (pronto)
    );

    function automatic obs_t observa();
        obs_t o;
        o.leds     = leds;
        o.endereco = endereco;
        o.ocupado  = ocupado;
        o.pronto   = pronto;
        return o;
    endfunction

    task automatic verifica(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_falha++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Expected outputs per cycle for a run started at edge 0, cycle 1 first.
    task automatic empilha_seq(input int nv);
        obs_t e;
        for (int c = 1; c <= (nv + 1) * N + 1; c++) begin
            int ent = (c - 1) / N;
            int fase = (c - 1) % N;
            e.ocupado = 1'b1;
            if (c == (nv + 1) * N + 1) begin
                e.endereco = 4'(nv);
                e.leds     = 4'b0000;
                e.pronto   = 1'b1;
            end else begin
                e.endereco = 4'(ent);
                e.leds     = (fase >= 2 && fase < 2 + TL) ? rom[ent] : 4'b0000;
                e.pronto   = 1'b0;
            end
            esperado_q.push_back(e);
        end
        e.leds = 4'b0000; e.endereco = 4'(nv); e.ocupado = 1'b0; e.pronto = 1'b0;
        esperado_q.push_back(e);
    endtask

    task automatic ciclo(input string tag, input int c);
        obs_t exp;
        @(posedge clock);
        #1;
        if (esperado_q.size() == 0) begin
            verifica($sformatf("%s scoreboard empty c%0d", tag, c), 10'(observa()), 10'h3ff);
        end else begin
            exp = esperado_q.pop_front();
            verifica($sformatf("%s c%0d", tag, c), 10'(observa()), 10'(exp));
        end
    endtask

    // Runs one whole sequence; perturba>0 pulses iniciar and moves nivel in that cycle.
    task automatic corre(input string tag, input int nv, input int perturba);
        int c;
        nivel   = 4'(nv);
        iniciar = 1'b1;
        empilha_seq(nv);
        ciclo(tag, 1);
        iniciar = 1'b0;
        c = 2;
        while (esperado_q.size() > 0) begin
            if (c == perturba) begin
                iniciar = 1'b1;
                nivel   = 4'd5;
            end
            ciclo(tag, c);
            iniciar = 1'b0;
            c++;
        end
    endtask

    task automatic ocioso(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
            verifica($sformatf("%s leds k%0d", tag, k), 10'(leds), 10'(0));
            verifica($sformatf("%s ocupado k%0d", tag, k), 10'(ocupado), 10'(0));
            verifica($sformatf("%s pronto k%0d", tag, k), 10'(pronto), 10'(0));
        end
    endtask

    initial begin
        reset   = 1'b0;
        iniciar = 1'b0;
        abortar = 1'b0;
        nivel   = 4'd0;
        for (int i = 0; i < 16; i++) rom[i] = 4'b0001 << (i % 4);
        rom[0] = 4'b0001;
        rom[1] = 4'b0100;
        rom[7] = 4'b0110;

        #1;
        verifica("reset outputs", 10'(observa()), 10'(0));
        @(posedge clock); @(posedge clock);
        #1;
        reset = 1'b1;
        ocioso("after reset", 2);

        corre("basic", 1, -1);

        rom[0] = 4'b1000;
        corre("single", 0, -1);

        corre("full", 15, -1);

        rom[0] = 4'b0001;
        corre("ignored", 1, 4);
        nivel = 4'd1;

        // Abort during the second entry's dark phase (cycle 13).
        iniciar = 1'b1;
        empilha_seq(1);
        ciclo("abort run", 1);
        iniciar = 1'b0;
        for (int c = 2; c <= 13; c++) ciclo("abort run", c);
        abortar = 1'b1;
        @(posedge clock);
        #1;
        abortar = 1'b0;
        esperado_q.delete();
        verifica("abort leds", 10'(leds), 10'(0));
        verifica("abort ocupado", 10'(ocupado), 10'(0));
        verifica("abort pronto", 10'(pronto), 10'(0));
        ocioso("post abort", 3 * N);

        abortar = 1'b1;
        iniciar = 1'b1;
        ocioso("abort beats start", 1);
        abortar = 1'b0;
        iniciar = 1'b0;
        ocioso("abort beats start idle", 2);

        corre("restart", 1, -1);

        // Asynchronous reset in the middle of the first lit phase.
        nivel   = 4'd1;
        iniciar = 1'b1;
        empilha_seq(1);
        ciclo("reset run", 1);
        iniciar = 1'b0;
        for (int c = 2; c <= 3; c++) ciclo("reset run", c);
        esperado_q.delete();
        #3;
        reset = 1'b0;
        #1;
        verifica("async reset outputs", 10'(observa()), 10'(0));
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1;
            verifica($sformatf("post reset k%0d", k), 10'(observa()), 10'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_falha);
        $finish;
    end

endmodule

`default_nettype wire
